// File: rtl/sipo_frame_controller_pkg.sv
// ---------------------------------------------------------------------------
// sipo_frame_controller_pkg
//   Shared definitions for the serial-in/parallel-out frame controller:
//   default frame geometry and the FSM state encoding.
// ---------------------------------------------------------------------------
package sipo_frame_controller_pkg;

  // Default frame geometry. CNT_W must satisfy 2**CNT_W > WIDTH.
  localparam int WIDTH_DEF = 5;
  localparam int CNT_W_DEF = 3;

  // Frame sequencing states.
  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_SHIFT = 1'b1
  } state_e;

endpackage : sipo_frame_controller_pkg

// File: rtl/sipo_frame_controller_bit_counter.sv
// ---------------------------------------------------------------------------
// sipo_frame_controller_bit_counter
//   Counts accepted serial bits within a frame.
//   Ports:
//     clk      - system clock, rising edge
//     reset    - synchronous, active-high; clears the count
//     clr      - synchronous clear (frame start / frame complete)
//     en       - increment by one (ignored when clr is high)
//     count    - current bit count
//     terminal - count has reached WIDTH-1 (next accepted bit ends the frame)
// ---------------------------------------------------------------------------
module sipo_frame_controller_bit_counter #(
  parameter int WIDTH = 5,
  parameter int CNT_W = 3
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             clr,
  input  logic             en,
  output logic [CNT_W-1:0] count,
  output logic             terminal
);

  logic [CNT_W-1:0] count_q;
  logic [CNT_W-1:0] count_d;

  always_comb begin
    // NOTE: assign a default first so every path drives count_d; no latch.
    count_d = count_q;
    if (clr) begin
      count_d = '0;
    end else if (en) begin
      count_d = count_q + CNT_W'(1);
    end
  end

  // NOTE: sequential state uses non-blocking assignments only.
  always_ff @(posedge clk) begin
    if (reset) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign count    = count_q;
  assign terminal = (count_q == CNT_W'(WIDTH - 1));

endmodule : sipo_frame_controller_bit_counter

// File: rtl/sipo_frame_controller.sv
// ---------------------------------------------------------------------------
// sipo_frame_controller
//   Captures WIDTH-bit serial frames into a parallel word and offers each
//   completed word to a consumer with a valid/ready handshake. The shift
//   register and the holding register are independent, so a new frame may
//   shift while the previous word still waits for the consumer; a word that
//   completes while the holding register is still occupied is dropped and
//   flagged on the sticky overrun output.
//   Ports:
//     clk, reset   - system clock; synchronous active-high reset
//     frame_start  - begin or restart a frame
//     in           - serial data bit, qualified by bit_valid
//     bit_valid    - 'in' carries a data bit this cycle
//     out_ready    - consumer accepts data_out this cycle
//     clr_err      - clear sticky overrun
//     data_out     - completed word, first received bit in data_out[0]
//     out_valid    - data_out holds an unconsumed word
//     busy         - frame in progress
//     bit_count    - bits accepted in the current frame
//     overrun      - sticky: a completed word was dropped
// ---------------------------------------------------------------------------
module sipo_frame_controller
  import sipo_frame_controller_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEF,
  parameter int CNT_W = CNT_W_DEF
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             frame_start,
  input  logic             in,
  input  logic             bit_valid,
  input  logic             out_ready,
  input  logic             clr_err,
  output logic [WIDTH-1:0] data_out,
  output logic             out_valid,
  output logic             busy,
  output logic [CNT_W-1:0] bit_count,
  output logic             overrun
);

  state_e           state_q, state_d;
  logic [WIDTH-1:0] shift_q, shift_d;
  logic [WIDTH-1:0] data_q, data_d;
  logic             out_valid_q, out_valid_d;
  logic             overrun_q, overrun_d;

  logic             accept;    // data bit taken into the shift register
  logic             last_bit;  // accepted bit completes the frame
  logic             load;      // completed word goes into the holding register
  logic             drop;      // completed word lost to an occupied holding register
  logic             terminal;
  logic [WIDTH-1:0] word;      // completed word including the current bit

  // ---- FSM: state register ------------------------------------------------
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // ---- FSM: next state ------------------------------------------------------
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_IDLE:  if (frame_start) state_d = ST_SHIFT;
      ST_SHIFT: begin
        // A restart keeps us in SHIFT even if it coincides with a final bit.
        if (frame_start)   state_d = ST_SHIFT;
        else if (last_bit) state_d = ST_IDLE;
      end
      default:  state_d = ST_IDLE;
    endcase
  end

  // ---- FSM: outputs / control strobes --------------------------------------
  always_comb begin
    busy     = (state_q == ST_SHIFT);
    // The frame_start cycle never carries a data bit.
    accept   = busy && bit_valid && !frame_start;
    last_bit = accept && terminal;
    // The holding register is free if empty or being drained this same cycle.
    load     = last_bit && (!out_valid_q || out_ready);
    drop     = last_bit && out_valid_q && !out_ready;
  end

  sipo_frame_controller_bit_counter #(
    .WIDTH (WIDTH),
    .CNT_W (CNT_W)
  ) u_bit_counter (
    .clk      (clk),
    .reset    (reset),
    .clr      (frame_start || last_bit),
    .en       (accept),
    .count    (bit_count),
    .terminal (terminal)
  );

  // ---- Datapath ------------------------------------------------------------
  // Right shift with the new bit at the MSB leaves the first bit in [0].
  assign word = {in, shift_q[WIDTH-1:1]};

  always_comb begin
    shift_d     = shift_q;
    data_d      = data_q;
    out_valid_d = out_valid_q;
    overrun_d   = overrun_q;

    if (frame_start) begin
      shift_d = '0;
    end else if (accept) begin
      shift_d = word;
    end

    if (load) begin
      data_d      = word;
      out_valid_d = 1'b1;
    end else if (out_valid_q && out_ready) begin
      out_valid_d = 1'b0;
    end

    // A drop in the same cycle as clr_err leaves the flag set.
    if (drop) begin
      overrun_d = 1'b1;
    end else if (clr_err) begin
      overrun_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      shift_q     <= '0;
      data_q      <= '0;
      out_valid_q <= 1'b0;
      overrun_q   <= 1'b0;
    end else begin
      shift_q     <= shift_d;
      data_q      <= data_d;
      out_valid_q <= out_valid_d;
      overrun_q   <= overrun_d;
    end
  end

  assign data_out  = data_q;
  assign out_valid = out_valid_q;
  assign overrun   = overrun_q;

endmodule : sipo_frame_controller
